// File: rtl/xbi_pkg.sv
// ----------------------------------------------------------------------------
// xbi_pkg
// Shared definitions for the crossbar-interface packet reader:
//   - drain FSM state encoding (IDLE, HDR, STREAM, ADV)
//   - header length field width and default bit position
//   - default slot size, shared with the FIFO pointer instantiation
//   - helper that classifies a header length as illegal
// ----------------------------------------------------------------------------
package xbi_pkg;

    localparam logic [1:0] XBI_IDLE   = 2'd0;
    localparam logic [1:0] XBI_HDR    = 2'd1;
    localparam logic [1:0] XBI_STREAM = 2'd2;
    localparam logic [1:0] XBI_ADV    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = XBI_IDLE,
        ST_HDR    = XBI_HDR,
        ST_STREAM = XBI_STREAM,
        ST_ADV    = XBI_ADV
    } xbi_state_e;

    // Header length field: 8 bits wide, default position at bit 0.
    localparam int XBI_LEN_W   = 8;
    localparam int XBI_LEN_LSB = 0;

    // Slot size in words; also the largest legal packet length.
    localparam logic [9:0] XBI_PACKET_SIZE = 10'd144;

    // A length of zero, or one larger than the slot, cannot be honoured.
    // The compare is unsigned with the 8-bit length zero-extended.
    function automatic logic xbi_len_bad(input logic [XBI_LEN_W-1:0] len,
                                         input logic [9:0]           pkt_size);
        return (len == '0) || ({2'b00, len} > pkt_size);
    endfunction

endpackage

// File: rtl/xbi_skid2.sv
// ----------------------------------------------------------------------------
// xbi_skid2
// Two-entry output buffer holding {data, sop, eop}. The head entry drives the
// output stream directly, so the visible word only changes on a pop.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset (empties the buffer)
//   i_push          write i_data/i_sop/i_eop into the tail entry
//   i_data/i_sop/i_eop  entry contents to write
//   i_pop           consumer took the head entry (ignored when empty)
//   o_valid         buffer holds at least one entry
//   o_data/o_sop/o_eop  head entry contents
//   o_count         occupancy, 0..2
// ----------------------------------------------------------------------------
module xbi_skid2 #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_sop,
    input  logic         i_eop,
    input  logic         i_pop,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output logic         o_sop,
    output logic         o_eop,
    output logic [1:0]   o_count
);

    logic [W+1:0] r_mem [2];
    logic         r_wr;
    logic         r_rd;
    logic [1:0]   r_count;

    logic         w_do_pop;
    logic         w_do_push;

    assign w_do_pop  = i_pop && (r_count != 2'd0);
    // When full, a push is only accepted alongside a pop: the tail slot is the
    // head slot being vacated, whose old contents are still what drives the
    // output during this cycle.
    assign w_do_push = i_push && ((r_count != 2'd2) || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_wr    <= 1'b0;
            r_rd    <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr] <= {i_data, i_sop, i_eop};
                r_wr        <= ~r_wr;
            end
            if (w_do_pop) begin
                r_rd <= ~r_rd;
            end
            r_count <= r_count + {1'b0, w_do_push} - {1'b0, w_do_pop};
        end
    end

    assign o_valid = (r_count != 2'd0);
    assign {o_data, o_sop, o_eop} = r_mem[r_rd];
    assign o_count = r_count;

endmodule

// File: rtl/xbi_pkt_reader.sv
// ----------------------------------------------------------------------------
// xbi_pkt_reader
// Drains one packet at a time from the head slot of a crossbar packet FIFO.
// The header word is read first and supplies the packet length; the rest of
// the slot is read word by word and streamed out, then the slot is released
// with a one-cycle advance pulse.
//
// Ports:
//   clk, rst          read-domain clock, synchronous active-high reset
//   i_fifo_empty      slot FIFO empty (registered upstream)
//   i_fifo_base       word address of the head slot (registered upstream)
//   o_fifo_advance    one-cycle pulse: head slot consumed
//   o_mem_en/o_mem_adr  buffer memory read port, data returns next cycle
//   i_mem_data        read data, valid the cycle after o_mem_en
//   o_data/o_valid/o_sop/o_eop  output stream (head of the output buffer)
//   i_stall           consumer not ready
//   o_len_err         one-cycle pulse when the header length is illegal
//
// Handshake: a word transfers in every cycle where o_valid is high and
// i_stall is low. While o_valid is high and i_stall is high the word and its
// sop/eop tags are held unchanged.
// ----------------------------------------------------------------------------
module xbi_pkt_reader
    import xbi_pkg::*;
#(
    parameter int         DATA_WIDTH  = 16,
    parameter logic [9:0] PACKET_SIZE = XBI_PACKET_SIZE,
    parameter int         LEN_LSB     = XBI_LEN_LSB
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_fifo_empty,
    input  logic [9:0]            i_fifo_base,
    output logic                  o_fifo_advance,
    output logic                  o_mem_en,
    output logic [9:0]            o_mem_adr,
    input  logic [DATA_WIDTH-1:0] i_mem_data,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_sop,
    output logic                  o_eop,
    input  logic                  i_stall,
    output logic                  o_len_err
);

    xbi_state_e             r_state;
    xbi_state_e             w_next_state;

    logic [9:0]             r_base_q;
    logic [XBI_LEN_W-1:0]   r_k;
    logic [XBI_LEN_W-1:0]   r_len_q;
    logic                   r_inflight;
    logic                   r_inflight_eop;

    logic [XBI_LEN_W-1:0]   w_len_raw;
    logic                   w_len_bad;
    logic [XBI_LEN_W-1:0]   w_len_eff;
    logic [XBI_LEN_W-1:0]   w_len_cur;

    logic [1:0]             w_count;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_push_sop;
    logic                   w_push_eop;
    logic [2:0]             w_next_occ;
    logic                   w_room;
    logic                   w_issue;

    // Header length decode; an illegal length drains the whole slot.
    assign w_len_raw = i_mem_data[LEN_LSB +: XBI_LEN_W];
    assign w_len_bad = xbi_len_bad(w_len_raw, PACKET_SIZE);
    assign w_len_eff = w_len_bad ? PACKET_SIZE[XBI_LEN_W-1:0] : w_len_raw;

    // In HDR the length is still on the memory bus, not yet in r_len_q.
    assign w_len_cur = (r_state == ST_HDR) ? w_len_eff : r_len_q;

    assign w_pop = o_valid && !i_stall;

    // Memory data is pushed in HDR (the header) and whenever a body read
    // returns. Nothing else ever writes the output buffer.
    assign w_push = (r_state == ST_HDR) || r_inflight;

    // A read issued now lands in the buffer next cycle. It is safe to issue
    // only if the occupancy after this cycle's push/pop leaves a free entry
    // for it even if the consumer stalls next cycle. Counting this cycle's
    // pop is what lets two entries sustain one word per cycle.
    assign w_next_occ = {1'b0, w_count} - {2'b00, w_pop} + {2'b00, w_push};
    assign w_room     = (w_next_occ <= 3'd1);

    always_comb begin
        w_next_state = r_state;
        o_mem_en     = 1'b0;
        o_mem_adr    = 10'd0;
        o_fifo_advance = 1'b0;
        o_len_err    = 1'b0;
        w_push_sop   = 1'b0;
        w_push_eop   = 1'b0;
        w_issue      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (!i_fifo_empty) begin
                    o_mem_en     = 1'b1;
                    o_mem_adr    = i_fifo_base;
                    w_next_state = ST_HDR;
                end
            end
            ST_HDR: begin
                w_push_sop   = 1'b1;
                w_push_eop   = (w_len_eff == 8'd1);
                o_len_err    = w_len_bad;
                w_issue      = (w_len_eff > 8'd1) && w_room;
                w_next_state = ST_STREAM;
            end
            ST_STREAM: begin
                w_push_eop = r_inflight_eop;
                w_issue    = (r_k < r_len_q) && w_room;
                if (w_pop && o_eop) begin
                    w_next_state = ST_ADV;
                end
            end
            ST_ADV: begin
                o_fifo_advance = 1'b1;
                w_next_state   = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase

        if (w_issue) begin
            o_mem_en  = 1'b1;
            o_mem_adr = r_base_q + {2'b00, r_k};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_base_q       <= 10'd0;
            r_k            <= '0;
            r_len_q        <= '0;
            r_inflight     <= 1'b0;
            r_inflight_eop <= 1'b0;
        end else begin
            r_state <= w_next_state;

            if ((r_state == ST_IDLE) && !i_fifo_empty) begin
                r_base_q <= i_fifo_base;
                r_k      <= 8'd1;
            end

            if (r_state == ST_HDR) begin
                r_len_q <= w_len_eff;
            end

            if (w_issue) begin
                r_k <= r_k + 8'd1;
            end

            // Reads return in order, so the read of index len-1 carries eop.
            r_inflight     <= w_issue;
            r_inflight_eop <= w_issue && (r_k == (w_len_cur - 8'd1));
        end
    end

    xbi_skid2 #(
        .W(DATA_WIDTH)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (i_mem_data),
        .i_sop   (w_push_sop),
        .i_eop   (w_push_eop),
        .i_pop   (!i_stall),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_sop   (o_sop),
        .o_eop   (o_eop),
        .o_count (w_count)
    );

endmodule

// File: tb/tb_xbi_pkt_reader.sv
// ----------------------------------------------------------------------------
// tb_xbi_pkt_reader
// Directed bench for xbi_pkt_reader. A behavioural synchronous RAM returns
// 16'h5000 + address for body words; header words are placed per test.
// ----------------------------------------------------------------------------
module tb_xbi_pkt_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_fifo_empty;
    logic [9:0]  i_fifo_base;
    logic        o_fifo_advance;
    logic        o_mem_en;
    logic [9:0]  o_mem_adr;
    logic [15:0] i_mem_data;
    logic [15:0] o_data;
    logic        o_valid;
    logic        o_sop;
    logic        o_eop;
    logic        i_stall;
    logic        o_len_err;

    int n_checks = 0;
    int n_errors = 0;

    // Clock / reset block
    always #5 clk = ~clk;

    // Buffer memory model: synchronous read, one cycle latency.
    logic [15:0] mem [0:1023];
    logic [15:0] mem_q = 16'h0000;
    always @(posedge clk) begin
        if (o_mem_en) mem_q <= mem[o_mem_adr];
    end
    assign i_mem_data = mem_q;

    xbi_pkt_reader #(
        .DATA_WIDTH  (16),
        .PACKET_SIZE (10'd144),
        .LEN_LSB     (0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_fifo_empty   (i_fifo_empty),
        .i_fifo_base    (i_fifo_base),
        .o_fifo_advance (o_fifo_advance),
        .o_mem_en       (o_mem_en),
        .o_mem_adr      (o_mem_adr),
        .i_mem_data     (i_mem_data),
        .o_data         (o_data),
        .o_valid        (o_valid),
        .o_sop          (o_sop),
        .o_eop          (o_eop),
        .i_stall        (i_stall),
        .o_len_err      (o_len_err)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before 500us");
        $fatal(1, "watchdog expired");
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Runs one packet from an idle reader: header read at cycle 0, then
    // cycles 1.. until the advance pulse (bounded). Body word j is expected
    // to be 16'h5000 + base + j; word 0 is the header itself.
    task automatic stream_pkt(input string tag, input logic [9:0] base, input logic [15:0] hdr,
                              input int exp_len, input int exp_err,
                              input int stall_lo, input int stall_hi);
        int          j = 0;
        int          reads = 0;
        int          errs = 0;
        int          advs = 0;
        int          stall_reads = 0;
        bit          hold = 1'b0;
        logic [17:0] held = '0;
        logic [15:0] exp_w;

        tick();
        i_fifo_empty = 1'b0;
        i_fifo_base  = base;
        i_stall      = 1'b0;
        #1;
        chk_b({tag, " hdr_rd_en"}, o_mem_en, 1'b1);
        chk_w({tag, " hdr_rd_adr"}, 32'(o_mem_adr), 32'(base));
        reads = 1;

        for (int c = 1; c < 600 && advs == 0; c++) begin
            tick();
            i_fifo_empty = 1'b1;
            i_stall      = (c >= stall_lo) && (c <= stall_hi);
            #1;
            if (o_mem_en) begin
                reads++;
                if (i_stall) stall_reads++;
            end
            if (o_len_err) errs++;
            if (hold) begin
                chk_w({tag, " stall_hold"}, 32'({o_valid, o_sop, o_eop, o_data}), 32'({1'b1, held}));
            end
            hold = o_valid && i_stall;
            held = {o_sop, o_eop, o_data};
            if (o_valid && !i_stall) begin
                exp_w = (j == 0) ? hdr : 16'h5000 + 16'(base) + 16'(j);
                chk_w({tag, " data"}, 32'(o_data), 32'(exp_w));
                chk_b({tag, " sop"}, o_sop, (j == 0));
                chk_b({tag, " eop"}, o_eop, (j == exp_len - 1));
                j++;
            end
            if (o_fifo_advance) begin
                advs++;
                chk_w({tag, " adv_after_last_word"}, j, exp_len);
            end
        end
        chk_w({tag, " adv_seen"}, advs, 1);

        tick();
        chk_b({tag, " adv_single_pulse"}, o_fifo_advance, 1'b0);
        chk_b({tag, " idle_no_read"}, o_mem_en, 1'b0);
        chk_w({tag, " words"}, j, exp_len);
        chk_w({tag, " reads"}, reads, exp_len);
        chk_w({tag, " len_err_pulses"}, errs, exp_err);
        chk_w({tag, " reads_while_stalled"}, stall_reads, 0);
        i_stall = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < 1024; a++) mem[a] = 16'h5000 + 16'(a);
        mem[0]   = 16'h0003;
        mem[144] = 16'h0004;
        mem[300] = 16'h7701;
        mem[432] = 16'h0008;
        mem[576] = 16'hAB00;
        mem[720] = 16'h12C8;
        mem[864] = 16'h0006;

        rst          = 1'b1;
        i_fifo_empty = 1'b1;
        i_fifo_base  = 10'd0;
        i_stall      = 1'b0;
        tick(); tick(); tick();
        chk_b("rst valid", o_valid, 1'b0);
        chk_b("rst sop", o_sop, 1'b0);
        chk_b("rst eop", o_eop, 1'b0);
        chk_b("rst adv", o_fifo_advance, 1'b0);
        chk_b("rst mem_en", o_mem_en, 1'b0);
        chk_b("rst len_err", o_len_err, 1'b0);
        chk_w("rst mem_adr", 32'(o_mem_adr), 32'd0);
        chk_w("rst data", 32'(o_data), 32'd0);
        rst = 1'b0;
        tick();

        // len=4 at base 144, no stall, cycle-by-cycle
        tick(); i_fifo_empty = 1'b0; i_fifo_base = 10'd144; #1;
        chk_b("t4 c0 en", o_mem_en, 1'b1);
        chk_w("t4 c0 adr", 32'(o_mem_adr), 32'd144);
        chk_b("t4 c0 valid", o_valid, 1'b0);
        tick(); i_fifo_empty = 1'b1; #1;
        chk_b("t4 c1 en", o_mem_en, 1'b1);
        chk_w("t4 c1 adr", 32'(o_mem_adr), 32'd145);
        chk_b("t4 c1 valid", o_valid, 1'b0);
        tick(); #1;
        chk_b("t4 c2 valid", o_valid, 1'b1);
        chk_b("t4 c2 sop", o_sop, 1'b1);
        chk_b("t4 c2 eop", o_eop, 1'b0);
        chk_w("t4 c2 data", 32'(o_data), 32'h0004);
        chk_w("t4 c2 adr", 32'(o_mem_adr), 32'd146);
        tick(); #1;
        chk_w("t4 c3 data", 32'(o_data), 32'h5091);
        chk_b("t4 c3 sop", o_sop, 1'b0);
        chk_w("t4 c3 adr", 32'(o_mem_adr), 32'd147);
        tick(); #1;
        chk_w("t4 c4 data", 32'(o_data), 32'h5092);
        chk_b("t4 c4 en", o_mem_en, 1'b0);
        tick(); #1;
        chk_w("t4 c5 data", 32'(o_data), 32'h5093);
        chk_b("t4 c5 eop", o_eop, 1'b1);
        chk_b("t4 c5 adv", o_fifo_advance, 1'b0);
        tick(); #1;
        chk_b("t4 c6 valid", o_valid, 1'b0);
        chk_b("t4 c6 adv", o_fifo_advance, 1'b1);
        tick(); #1;
        chk_b("t4 c7 adv", o_fifo_advance, 1'b0);

        // len=1 at base 300: header is both sop and eop, single read
        tick(); i_fifo_empty = 1'b0; i_fifo_base = 10'd300; #1;
        chk_b("t1 c0 en", o_mem_en, 1'b1);
        chk_w("t1 c0 adr", 32'(o_mem_adr), 32'd300);
        tick(); i_fifo_empty = 1'b1; #1;
        chk_b("t1 c1 en", o_mem_en, 1'b0);
        tick(); #1;
        chk_b("t1 c2 valid", o_valid, 1'b1);
        chk_b("t1 c2 sop", o_sop, 1'b1);
        chk_b("t1 c2 eop", o_eop, 1'b1);
        chk_w("t1 c2 data", 32'(o_data), 32'h7701);
        chk_b("t1 c2 en", o_mem_en, 1'b0);
        tick(); #1;
        chk_b("t1 c3 adv", o_fifo_advance, 1'b1);
        chk_b("t1 c3 valid", o_valid, 1'b0);
        tick(); #1;
        chk_b("t1 c4 adv", o_fifo_advance, 1'b0);

        // len=8 with stall over cycles 3..6
        stream_pkt("stall8", 10'd432, 16'h0008, 8, 0, 3, 6);

        // Illegal lengths drain a full slot
        stream_pkt("len0", 10'd576, 16'hAB00, 144, 1, 0, -1);
        stream_pkt("len200", 10'd720, 16'h12C8, 144, 1, 0, -1);

        // Back-to-back slots: base 0 (len 3) then base 144
        tick(); i_fifo_empty = 1'b0; i_fifo_base = 10'd0; #1;
        chk_w("b2b c0 adr", 32'(o_mem_adr), 32'd0);
        tick(); #1;
        chk_w("b2b c1 adr", 32'(o_mem_adr), 32'd1);
        tick(); #1;
        chk_w("b2b c2 data", 32'(o_data), 32'h0003);
        chk_w("b2b c2 adr", 32'(o_mem_adr), 32'd2);
        tick(); #1;
        chk_w("b2b c3 data", 32'(o_data), 32'h5001);
        chk_b("b2b c3 en", o_mem_en, 1'b0);
        tick(); #1;
        chk_w("b2b c4 data", 32'(o_data), 32'h5002);
        chk_b("b2b c4 eop", o_eop, 1'b1);
        tick(); #1;
        chk_b("b2b c5 adv", o_fifo_advance, 1'b1);
        chk_b("b2b c5 no_reread", o_mem_en, 1'b0);
        stream_pkt("b2b slot1", 10'd144, 16'h0004, 4, 0, 0, -1);

        // Reset while word 3 of 6 is pending
        tick(); i_fifo_empty = 1'b0; i_fifo_base = 10'd864; #1;
        chk_w("rstmid c0 adr", 32'(o_mem_adr), 32'd864);
        tick(); i_fifo_empty = 1'b1; #1;
        tick(); #1;
        chk_w("rstmid c2 data", 32'(o_data), 32'h0006);
        tick(); #1;
        chk_w("rstmid c3 data", 32'(o_data), 32'h5361);
        tick(); #1;
        chk_w("rstmid c4 data", 32'(o_data), 32'h5362);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk_b("rstmid valid", o_valid, 1'b0);
        chk_b("rstmid sop", o_sop, 1'b0);
        chk_b("rstmid eop", o_eop, 1'b0);
        chk_b("rstmid adv", o_fifo_advance, 1'b0);
        chk_b("rstmid mem_en", o_mem_en, 1'b0);
        chk_b("rstmid len_err", o_len_err, 1'b0);
        chk_w("rstmid mem_adr", 32'(o_mem_adr), 32'd0);
        chk_w("rstmid data", 32'(o_data), 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_b("rstmid no_adv", o_fifo_advance, 1'b0);
            chk_b("rstmid no_valid", o_valid, 1'b0);
        end
        stream_pkt("after_rst", 10'd864, 16'h0006, 6, 0, 0, -1);

        // Final report
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
